// File: rtl/gnrl_pkg.sv
// Shared helpers for the gnrl_fifo codebase slice: width calculators used to
// size the occupancy counter and the read/write pointers.
package gnrl_pkg;

  // Smallest number of bits able to index v distinct values (ceil(log2(v))).
  function automatic int gnrl_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer width: one bit minimum so a depth-1 FIFO still has a legal pointer.
  function automatic int gnrl_ptr_w(input int dp);
    return (dp > 1) ? gnrl_clog2(dp) : 1;
  endfunction

endpackage

// File: rtl/gnrl_fifo_if.sv
// Handshake bundle for gnrl_fifo: push side (i_*), pop side (o_*) and status.
// slave is the FIFO's view, master is the producer/consumer environment view.
interface gnrl_fifo_if
  import gnrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int CW = gnrl_clog2(DP + 1)
);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat, count, full, empty
  );

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat, count, full, empty
  );
endinterface

// File: rtl/gnrl_fifo_ptr.sv
// Wrapping pointer counter: counts 0..DP-1 and returns to 0, so depths that
// are not a power of two wrap correctly.
module gnrl_fifo_ptr #(
  parameter int DP = 4,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_d, ptr_q;

  // Next pointer: hold, increment, or wrap from the last entry back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PW'(DP - 1)) ptr_d = '0;
      else                      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/gnrl_fifo.sv
// gnrl_fifo: DP-entry, DW-wide synchronous FIFO with valid/ready on both sides.
// Status (full/empty/i_rdy) derives only from the registered count, so there is
// no combinational o_rdy -> i_rdy path.
// Optional macro GNRL_FIFO_BYPASS_EN: when empty, an offered word is forwarded
// straight to the output in the same cycle if the consumer is ready.
module gnrl_fifo
  import gnrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int CW = gnrl_clog2(DP + 1)
) (
  input logic        clk,
  input logic        rst,
  gnrl_fifo_if.slave f
);
  localparam int PW = gnrl_ptr_w(DP);

  logic [CW-1:0] count_d, count_q;
  logic [DW-1:0] mem_d [DP];
  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          full, empty, push, pop, byp;

  assign full  = (count_q == CW'(DP));
  assign empty = (count_q == '0);

`ifdef GNRL_FIFO_BYPASS_EN
  // Empty with a ready consumer: the word passes through and is never stored.
  assign byp     = empty & f.i_vld & f.o_rdy;
  assign f.o_vld = ~empty | f.i_vld;
  assign f.o_dat = empty ? f.i_dat : mem_q[rd_ptr];
`else
  assign byp     = 1'b0;
  assign f.o_vld = ~empty;
  assign f.o_dat = mem_q[rd_ptr];
`endif

  // A pop needs a stored head; a bypassed word is not a stored-entry pop.
  assign push = f.i_vld & ~full & ~byp;
  assign pop  = ~empty & f.o_rdy;

  assign f.i_rdy = ~full;
  assign f.count = count_q;
  assign f.full  = full;
  assign f.empty = empty;

  gnrl_fifo_ptr #(.DP(DP), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  gnrl_fifo_ptr #(.DP(DP), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy register; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Storage next-state: only the entry at the write pointer changes on a push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = f.i_dat;
  end

  // Storage array: plain enabled registers, deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_gnrl_fifo.sv
// Directed testbench for gnrl_fifo: DP=4 instance for most scenarios and a
// DP=3 instance for non-power-of-two pointer wrap.
module tb_gnrl_fifo;
  import gnrl_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  gnrl_fifo_if #(.DW(32), .DP(4)) a_if ();
  gnrl_fifo_if #(.DW(32), .DP(3)) b_if ();

  gnrl_fifo #(.DW(32), .DP(4)) u_a (.clk(clk), .rst(rst), .f(a_if));
  gnrl_fifo #(.DW(32), .DP(3)) u_b (.clk(clk), .rst(rst), .f(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++; if (a_if.count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", a_if.empty); end
    n_cmp++; if (a_if.full  !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", a_if.full); end
    n_cmp++; if (a_if.i_rdy !== 1'b1) begin n_err++; $display("FAIL rst_i_rdy: got %b want 1", a_if.i_rdy); end
    n_cmp++; if (a_if.o_vld !== 1'b0) begin n_err++; $display("FAIL rst_o_vld: got %b want 0", a_if.o_vld); end
    n_cmp++; if (b_if.count !== 2'd0) begin n_err++; $display("FAIL rst_b_count: got %0d want 0", b_if.count); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    a_if.o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.i_vld = 1'b1;
      a_if.i_dat = vals[i];
      cyc();
    end
    n_cmp++; if (a_if.count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", a_if.count); end
    n_cmp++; if (a_if.full  !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", a_if.full); end
    n_cmp++; if (a_if.i_rdy !== 1'b0) begin n_err++; $display("FAIL fill_i_rdy: got %b want 0", a_if.i_rdy); end
    a_if.i_dat = 32'h55;
    cyc();
    a_if.i_vld = 1'b0;
    n_cmp++; if (a_if.count !== 3'd4) begin n_err++; $display("FAIL fifth_push_count: got %0d want 4", a_if.count); end
    a_if.o_rdy = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (a_if.o_vld !== 1'b1) begin n_err++; $display("FAIL drain_o_vld[%0d]: got %b want 1", i, a_if.o_vld); end
      n_cmp++; if (a_if.o_dat !== vals[i]) begin n_err++; $display("FAIL drain_o_dat[%0d]: got %h want %h", i, a_if.o_dat, vals[i]); end
      cyc();
    end
    a_if.o_rdy = 1'b0;
    #1;
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", a_if.empty); end
    n_cmp++; if (a_if.o_vld !== 1'b0) begin n_err++; $display("FAIL drain_o_vld_end: got %b want 0", a_if.o_vld); end
  endtask

  task automatic test_back_to_back();
    a_if.o_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_if.i_vld = 1'b1;
      a_if.i_dat = 32'h100 + i;
      cyc();
    end
    a_if.o_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_if.i_dat = 32'h102 + k;
      #1;
      n_cmp++; if (a_if.count !== 3'd2) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, a_if.count); end
      n_cmp++; if (a_if.o_dat !== 32'h100 + k) begin n_err++; $display("FAIL b2b_o_dat[%0d]: got %h want %h", k, a_if.o_dat, 32'h100 + k); end
      cyc();
    end
    a_if.i_vld = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (a_if.o_dat !== 32'h10A + k) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h want %h", k, a_if.o_dat, 32'h10A + k); end
      cyc();
    end
    a_if.o_rdy = 1'b0;
    #1;
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", a_if.empty); end
  endtask

  task automatic test_full_pop();
    a_if.o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.i_vld = 1'b1;
      a_if.i_dat = 32'h200 + i;
      cyc();
    end
    a_if.i_dat = 32'h2FF;
    a_if.o_rdy = 1'b1;
    #1;
    n_cmp++; if (a_if.i_rdy !== 1'b0) begin n_err++; $display("FAIL fullpop_i_rdy: got %b want 0", a_if.i_rdy); end
    n_cmp++; if (a_if.o_dat !== 32'h200) begin n_err++; $display("FAIL fullpop_head: got %h want 200", a_if.o_dat); end
    cyc();
    a_if.i_vld = 1'b0;
    #1;
    n_cmp++; if (a_if.count !== 3'd3) begin n_err++; $display("FAIL fullpop_count: got %0d want 3", a_if.count); end
    n_cmp++; if (a_if.i_rdy !== 1'b1) begin n_err++; $display("FAIL fullpop_i_rdy_next: got %b want 1", a_if.i_rdy); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (a_if.o_dat !== 32'h200 + i) begin n_err++; $display("FAIL fullpop_drain[%0d]: got %h want %h", i, a_if.o_dat, 32'h200 + i); end
      cyc();
    end
    a_if.o_rdy = 1'b0;
    #1;
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL fullpop_empty: got %b want 1", a_if.empty); end
  endtask

  task automatic test_wrap_dp3();
    logic [31:0] stall;
    int          push_val;
    int          exp_val;
    int          cycles;
    logic        did_push;
    logic        did_pop;
    stall    = 32'hB3C5_69A7;
    push_val = 0;
    exp_val  = 0;
    cycles   = 0;
    while (exp_val < 20 && cycles < 400) begin
      b_if.i_vld = (push_val < 20);
      b_if.i_dat = push_val;
      b_if.o_rdy = stall[cycles % 32];
      #1;
      did_push = b_if.i_vld & b_if.i_rdy;
      did_pop  = b_if.o_vld & b_if.o_rdy;
      if (did_pop) begin
        n_cmp++; if (b_if.o_dat !== 32'(exp_val)) begin n_err++; $display("FAIL wrap_o_dat[%0d]: got %0d want %0d", exp_val, b_if.o_dat, exp_val); end
        exp_val++;
      end
      n_cmp++; if (b_if.count > 2'd3) begin n_err++; $display("FAIL wrap_count: got %0d want <=3", b_if.count); end
      cyc();
      if (did_push) push_val++;
      cycles++;
    end
    b_if.i_vld = 1'b0;
    b_if.o_rdy = 1'b0;
    n_cmp++; if (exp_val != 20) begin n_err++; $display("FAIL wrap_timeout: got %0d words want 20", exp_val); end
    #1;
    n_cmp++; if (b_if.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", b_if.empty); end
  endtask

  task automatic test_bypass();
    a_if.i_vld = 1'b1;
    a_if.i_dat = 32'hA5A5_A5A5;
    a_if.o_rdy = 1'b1;
    #1;
`ifdef GNRL_FIFO_BYPASS_EN
    n_cmp++; if (a_if.o_vld !== 1'b1) begin n_err++; $display("FAIL byp_o_vld: got %b want 1", a_if.o_vld); end
    n_cmp++; if (a_if.o_dat !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL byp_o_dat: got %h want a5a5a5a5", a_if.o_dat); end
    cyc();
    a_if.i_vld = 1'b0;
    #1;
    n_cmp++; if (a_if.count !== 3'd0) begin n_err++; $display("FAIL byp_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.o_vld !== 1'b0) begin n_err++; $display("FAIL byp_o_vld_next: got %b want 0", a_if.o_vld); end
`else
    n_cmp++; if (a_if.o_vld !== 1'b0) begin n_err++; $display("FAIL nobyp_o_vld: got %b want 0", a_if.o_vld); end
    cyc();
    a_if.i_vld = 1'b0;
    #1;
    n_cmp++; if (a_if.o_vld !== 1'b1) begin n_err++; $display("FAIL nobyp_o_vld_next: got %b want 1", a_if.o_vld); end
    n_cmp++; if (a_if.o_dat !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL nobyp_o_dat: got %h want a5a5a5a5", a_if.o_dat); end
    cyc();
    #1;
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL nobyp_empty: got %b want 1", a_if.empty); end
`endif
    a_if.o_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_if.o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_if.i_vld = 1'b1;
      a_if.i_dat = 32'h300 + i;
      cyc();
    end
    n_cmp++; if (a_if.count !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_count: got %0d want 3", a_if.count); end
    a_if.o_rdy = 1'b1;
    rst = 1'b1;
    cyc();
    n_cmp++; if (a_if.count !== 3'd0) begin n_err++; $display("FAIL rstmid_count_1: got %0d want 0", a_if.count); end
    cyc();
    rst = 1'b0;
    a_if.i_vld = 1'b0;
    a_if.o_rdy = 1'b0;
    #1;
    n_cmp++; if (a_if.count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.empty !== 1'b1) begin n_err++; $display("FAIL rstmid_empty: got %b want 1", a_if.empty); end
    n_cmp++; if (a_if.i_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_i_rdy: got %b want 1", a_if.i_rdy); end
    n_cmp++; if (a_if.o_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_o_vld: got %b want 0", a_if.o_vld); end
    a_if.i_vld = 1'b1;
    a_if.i_dat = 32'h77;
    cyc();
    a_if.i_vld = 1'b0;
    #1;
    n_cmp++; if (a_if.o_dat !== 32'h77) begin n_err++; $display("FAIL rstmid_head: got %h want 77", a_if.o_dat); end
    n_cmp++; if (a_if.count !== 3'd1) begin n_err++; $display("FAIL rstmid_post_count: got %0d want 1", a_if.count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_if.i_vld = 1'b0;
    a_if.i_dat = '0;
    a_if.o_rdy = 1'b0;
    b_if.i_vld = 1'b0;
    b_if.i_dat = '0;
    b_if.o_rdy = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_wrap_dp3();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
